// File: rtl/add_32.sv
// rtl/add_32.sv - 32-bit two-level carry-lookahead adder with one registered output stage
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset; clears c/co/ovf/zero
//   a, b  32-bit operands, sampled every rising edge
//   c     registered sum, (a+b) mod 2^32
//   co    registered carry-out of bit 31
//   ovf   registered two's-complement overflow
//   zero  registered flag, 1 when the sum is zero (held 0 while in reset)

// 4-bit lookahead group: internal carries plus group generate/propagate.
// Every carry is a flat sum of products, so nothing ripples inside the group.
module cla_group_4 (
    input  logic [3:0] g,
    input  logic [3:0] p,
    input  logic       cin,
    output logic [3:0] carry,
    output logic       grp_g,
    output logic       grp_p
);
    always_comb begin
        carry[0] = cin;
        carry[1] = g[0] | (p[0] & cin);
        carry[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        carry[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cin);
        grp_g    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]);
        grp_p    = &p;
    end
endmodule

// Second-level lookahead across eight groups. grp_c[i] is the carry into
// group i; grp_c[8] is the carry out of the whole word. Each carry is built
// as an OR of AND terms (generate at group j, propagated through groups
// j+1..i-1), never as a chain through the previous carry.
module cla_lookahead_8 (
    input  logic [7:0] grp_g,
    input  logic [7:0] grp_p,
    input  logic       cin,
    output logic [8:0] grp_c
);
    logic term;

    always_comb begin
        grp_c = '0;
        term  = 1'b0;
        for (int i = 0; i <= 8; i++) begin
            // Carry-in term: propagates through all lower groups.
            term = cin;
            for (int k = 0; k < i; k++) begin
                term = term & grp_p[k];
            end
            grp_c[i] = term;
            // Generate terms from each lower group.
            for (int j = 0; j < i; j++) begin
                term = grp_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & grp_p[k];
                end
                grp_c[i] = grp_c[i] | term;
            end
        end
    end
endmodule

module add_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        co,
    output logic        ovf,
    output logic        zero
);
    logic [31:0] bit_g;
    logic [31:0] bit_p;
    logic [31:0] carry;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;
    logic [31:0] sum;
    logic        sum_co;
    logic        sum_ovf;

    assign bit_g = a & b;
    assign bit_p = a ^ b;

    for (genvar n = 0; n < 8; n++) begin : g_grp
        cla_group_4 u_grp (
            .g     (bit_g[4*n +: 4]),
            .p     (bit_p[4*n +: 4]),
            .cin   (grp_c[n]),
            .carry (carry[4*n +: 4]),
            .grp_g (grp_g[n]),
            .grp_p (grp_p[n])
        );
    end

    // The element adder has no carry-in; tie it off at the top level.
    cla_lookahead_8 u_look (
        .grp_g (grp_g),
        .grp_p (grp_p),
        .cin   (1'b0),
        .grp_c (grp_c)
    );

    assign sum     = bit_p ^ carry;
    assign sum_co  = grp_c[8];
    // Like-signed operands whose sum flips sign.
    assign sum_ovf = (a[31] ~^ b[31]) & (sum[31] ^ a[31]);

    always_ff @(posedge clk) begin
        if (rst) begin
            c    <= 32'h0;
            co   <= 1'b0;
            ovf  <= 1'b0;
            zero <= 1'b0;
        end else begin
            c    <= sum;
            co   <= sum_co;
            ovf  <= sum_ovf;
            zero <= ~|sum;
        end
    end
endmodule

// File: tb/tb_add_32.sv
// tb/tb_add_32.sv - self-checking bench for add_32: vector table, random model compare, reset sequences
module tb_add_32;
    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        co;
    logic        ovf;
    logic        zero;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        co;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t vecs[$];

    add_32 dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .c    (c),
        .co   (co),
        .ovf  (ovf),
        .zero (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: plain wide arithmetic; overflow judged by the signed range.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] us;
        longint      ss;
        logic        m_ovf;
        us    = {32'd0, x} + {32'd0, y};
        ss    = longint'($signed(x)) + longint'($signed(y));
        m_ovf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {us[31:0], us[32], m_ovf, (us[31:0] == 32'd0)};
    endfunction

    task automatic check(input string name, input logic [31:0] ec, input logic eco,
                         input logic eovf, input logic ezero);
        checks++;
        if ({c, co, ovf, zero} !== {ec, eco, eovf, ezero}) begin
            failures++;
            $display("FAIL %s: got c=%h co=%b ovf=%b zero=%b, expected c=%h co=%b ovf=%b zero=%b",
                     name, c, co, ovf, zero, ec, eco, eovf, ezero);
        end
    endtask

    // Drive on the falling edge, sample just after the following rising edge.
    task automatic step(input logic r, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [34:0] exp_v;
        logic [31:0] ra;
        logic [31:0] rb;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = 32'h0;
        b        = 32'h0;

        vecs.push_back('{32'h00000001, 32'h00000007, 32'h00000008, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1});
        vecs.push_back('{32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{32'h00000004, 32'hFFFFFFFC, 32'h00000000, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0});
        // A single carry walked across each 4-bit group boundary.
        vecs.push_back('{32'h0000000F, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h00000FFF, 32'h00000001, 32'h00001000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h000FFFFF, 32'h00000001, 32'h00100000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h00FFFFFF, 32'h00000001, 32'h01000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{32'h0FFFFFFF, 32'h00000001, 32'h10000000, 1'b0, 1'b0, 1'b0});

        // Reset held two edges with live operands, then released.
        step(1'b1, 32'h12345678, 32'h00000001);
        check("reset_edge1", 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h12345678, 32'h00000001);
        check("reset_edge2", 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h12345678, 32'h00000001);
        check("reset_release", 32'h12345679, 1'b0, 1'b0, 1'b0);

        // Outputs must hold between edges.
        @(negedge clk);
        a = 32'hDEADBEEF;
        b = 32'h00000000;
        #3;
        check("hold_between_edges", 32'h12345679, 1'b0, 1'b0, 1'b0);

        // Table vectors, back-to-back one per cycle.
        foreach (vecs[i]) begin
            step(1'b0, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d", i), vecs[i].c, vecs[i].co, vecs[i].ovf, vecs[i].zero);
        end

        // Back-to-back with reset landing on the edge that samples FFFFFFFF+1.
        step(1'b0, 32'h00000000, 32'h00000000);
        check("b2b_zero", 32'h0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h00000001, 32'h00000007);
        check("b2b_small", 32'h00000008, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hFFFFFFFF, 32'h00000001);
        check("midstream_reset", 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h00000003, 32'h00000004);
        check("after_midstream_reset", 32'h00000007, 1'b0, 1'b0, 1'b0);

        // Random operands against the wide-arithmetic model.
        for (int i = 0; i < 300; i++) begin
            case (i % 4)
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = ~ra + 32'd1; end
                2: begin ra = {1'b0, 31'($urandom)}; rb = {1'b0, 31'($urandom)}; end
                default: begin ra = {1'b1, 31'($urandom)}; rb = {1'b1, 31'($urandom)}; end
            endcase
            exp_v = model(ra, rb);
            step(1'b0, ra, rb);
            check($sformatf("rand%0d", i), exp_v[34:3], exp_v[2], exp_v[1], exp_v[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/add_32.md
Name: add_32

Overview:
- 32-bit two-operand unsigned/two's-complement adder with registered outputs.
- Combinational carry-lookahead core feeding one output register stage; used as the element adder in the datapath, e.g. PC+4 and branch-target generation.
- Produces the wrapped 32-bit sum plus carry-out, signed-overflow and zero flags.

Parameters:
- none (width fixed at 32 bits)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- a  input  32  operand A
- b  input  32  operand B
- c  output  32  registered sum, (a+b) mod 2^32
- co  output  1  registered carry-out of bit 31 (unsigned overflow)
- ovf  output  1  registered signed overflow: a[31]==b[31] and sum[31]!=a[31]
- zero  output  1  registered flag: 1 when the 32-bit sum equals 0

Behaviour:
- One clock; all state updates on rising edge of clk only.
- Reset: when rst=1 at a rising edge, c<=32'h0, co<=0, ovf<=0, zero<=0 on that edge. Reset has priority over new operands. Reset asserted mid-stream discards the in-flight sum.
- zero is 0 during and immediately after reset, not 1. It follows the sum only after the first non-reset edge.
- Latency: exactly 1 cycle. Operands sampled at edge N appear on c/co/ovf/zero after edge N.
- Operands are sampled every cycle; there is no enable or handshake. Outputs hold their value between edges.
- Arithmetic:
  - sum[32:0] = {1'b0,a} + {1'b0,b}
  - c = sum[31:0]; co = sum[32]
  - ovf = (a[31]~^b[31]) & (sum[31]^a[31])
  - zero = ~|sum[31:0]
- Wrap-around: results above 2^32-1 wrap modulo 2^32 with co=1, and do not saturate.
- Core structure:
  - Eight 4-bit carry-lookahead groups, each computing per-bit generate g=a&b and propagate p=a^b, group G/P and internal carries.
  - A second-level lookahead unit computes the group carries from group G/P, with carry-in fixed to 0.
  - Sum bits: s[i] = p[i] ^ carry[i].
  - No ripple chain longer than 4 bits. Behavioural "+" is not used in the core.
- Outputs carry no X after reset. Operand X is not masked.

Test Plan:
- Reset: rst=1 for 2 cycles with a=32'h12345678, b=32'h1 -> c=0, co=0, ovf=0, zero=0 throughout. Release rst -> next edge c=32'h12345679.
- Small add: a=32'h00000001, b=32'h00000007 -> one edge later c=32'h00000008, co=0, ovf=0, zero=0.
- Unsigned wrap: a=32'hFFFFFFFF, b=32'h00000001 -> c=32'h00000000, co=1, ovf=0, zero=1.
- Signed overflow: a=32'h7FFFFFFF, b=32'h00000001 -> c=32'h80000000, co=0, ovf=1, zero=0. Also a=32'h80000000, b=32'h80000000 -> c=0, co=1, ovf=1, zero=1.
- Full carry propagation: a=32'h0FFFFFFF, b=32'h00000001 -> c=32'h10000000. Walk a single carry across every 4-bit group boundary, e.g. a=32'h000000FF, b=1 -> c=32'h00000100.
- Back-to-back and mid-stream reset: change operands every cycle (0+0, 1+7, FFFFFFFF+1) -> each result appears exactly one edge after its operands. Assert rst on the third edge -> outputs go to 0, and the FFFFFFFF+1 result is never visible.
